// File: rtl/vu_pattern_gen.sv
// VU meter colour-word streamer: one GRB word per LED per start request.
// Optional peak-hold marker is compiled in with `define VU_PEAK_HOLD_EN.
module vu_pattern_gen #(
    parameter int          N_LEDS      = 20,
    parameter int          IDX_LINES   = 5,
    parameter int          GREEN_END   = 12,
    parameter int          YELLOW_END  = 16,
    parameter logic [7:0]  INTENSITY   = 8'h0F,
    parameter int          HOLD_FRAMES = 8
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_start,
    input  logic [IDX_LINES-1:0] i_level,
    input  logic                 i_ready,
    output logic [23:0]          o_data,
    output logic                 o_valid,
    output logic [IDX_LINES-1:0] o_idx,
    output logic                 o_last,
    output logic                 o_busy
);

    localparam logic [IDX_LINES-1:0] LAST_IDX = IDX_LINES'(N_LEDS - 1);
    localparam logic [IDX_LINES-1:0] MAX_LVL  = IDX_LINES'(N_LEDS);
    localparam logic [IDX_LINES-1:0] GREEN_L  = IDX_LINES'(GREEN_END);
    localparam logic [IDX_LINES-1:0] YELLOW_L = IDX_LINES'(YELLOW_END);

    localparam logic [23:0] GREEN  = {INTENSITY, 8'h00, 8'h00};
    localparam logic [23:0] YELLOW = {INTENSITY, INTENSITY, 8'h00};
    localparam logic [23:0] RED    = {8'h00, INTENSITY, 8'h00};
    localparam logic [23:0] PEAK   = {INTENSITY, INTENSITY, INTENSITY};

    // Reject configurations the index/level width cannot represent.
    if (N_LEDS < 1 || N_LEDS > (2**IDX_LINES) - 1) begin : g_bad_n
        $error("vu_pattern_gen: N_LEDS out of range for IDX_LINES");
    end
    if (HOLD_FRAMES < 0) begin : g_bad_hold
        $error("vu_pattern_gen: HOLD_FRAMES must be non-negative");
    end

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    state_t               state;
    logic [IDX_LINES-1:0] lvl;
    logic [IDX_LINES-1:0] lvl_in;
    logic [IDX_LINES-1:0] idx_nxt;
    logic [IDX_LINES-1:0] pk;
    logic [IDX_LINES-1:0] pk_nxt;

    // Zone colour for lit LEDs, peak marker or off for the rest.
    function automatic logic [23:0] colour(
        input logic [IDX_LINES-1:0] ix,
        input logic [IDX_LINES-1:0] lv,
        input logic [IDX_LINES-1:0] pkv
    );
        logic [23:0] c;
        c = 24'h000000;
        if (ix < lv) begin
            if (ix < GREEN_L)
                c = GREEN;
            else if (ix < YELLOW_L)
                c = YELLOW;
            else
                c = RED;
        end else if (pkv > lv && ix == pkv - 1'b1) begin
            c = PEAK;
        end
        return c;
    endfunction

    // Clamp the requested level and precompute the next LED index.
    always_comb begin
        lvl_in  = (i_level > MAX_LVL) ? MAX_LVL : i_level;
        idx_nxt = o_idx + 1'b1;
    end

`ifdef VU_PEAK_HOLD_EN
    localparam int HW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;

    logic [HW-1:0] hold;
    logic [HW-1:0] hold_nxt;

    // Peak follows rising levels at once, decays one LED per frame after the hold.
    always_comb begin
        pk_nxt   = pk;
        hold_nxt = hold;
        if (lvl_in >= pk) begin
            pk_nxt   = lvl_in;
            hold_nxt = HW'(HOLD_FRAMES);
        end else if (hold != '0) begin
            hold_nxt = hold - 1'b1;
        end else if (pk != '0) begin
            pk_nxt = pk - 1'b1;
        end
    end

    // Peak state advances once per accepted frame request.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            pk   <= '0;
            hold <= '0;
        end else if (state == IDLE && i_start) begin
            pk   <= pk_nxt;
            hold <= hold_nxt;
        end
    end
`else
    // Without peak hold the marker never matches any pixel.
    always_comb begin
        pk     = '0;
        pk_nxt = '0;
    end
`endif

    // Frame FSM with registered stream outputs.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state   <= IDLE;
            lvl     <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
            o_idx   <= '0;
            o_last  <= 1'b0;
            o_busy  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_start) begin
                        state   <= STREAM;
                        lvl     <= lvl_in;
                        o_valid <= 1'b1;
                        o_busy  <= 1'b1;
                        o_idx   <= '0;
                        o_last  <= (N_LEDS == 1);
                        o_data  <= colour('0, lvl_in, pk_nxt);
                    end
                end
                STREAM: begin
                    if (i_ready) begin
                        if (o_last) begin
                            state   <= IDLE;
                            o_valid <= 1'b0;
                            o_busy  <= 1'b0;
                            o_idx   <= '0;
                            o_last  <= 1'b0;
                            o_data  <= '0;
                        end else begin
                            o_idx   <= idx_nxt;
                            o_last  <= (idx_nxt == LAST_IDX);
                            o_data  <= colour(idx_nxt, lvl, pk);
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vu_pattern_gen.sv
// Self-checking bench for vu_pattern_gen against a frame-level model.
// Peak-hold expectations are modelled when VU_PEAK_HOLD_EN is defined.
module tb_vu_pattern_gen;

    localparam int N  = 20;
    localparam int IW = 5;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [IW-1:0] i_level;
    logic          i_ready;
    logic [23:0]   o_data;
    logic          o_valid;
    logic [IW-1:0] o_idx;
    logic          o_last;
    logic          o_busy;

    int checks = 0;
    int errors = 0;
    int m_pk   = 0;
    int m_hold = 0;

    vu_pattern_gen dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_level (i_level),
        .i_ready (i_ready),
        .o_data  (o_data),
        .o_valid (o_valid),
        .o_idx   (o_idx),
        .o_last  (o_last),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Green channel lit below the yellow/red boundary, red channel lit
    // from the yellow zone upward; peak marker is white.
    function automatic logic [23:0] ref_pixel(input int idx, input int lvl,
                                              input int pk);
        logic [7:0] g;
        logic [7:0] r;
        if (idx < lvl) begin
            g = (idx < 16) ? 8'h0F : 8'h00;
            r = (idx >= 12) ? 8'h0F : 8'h00;
            return {g, r, 8'h00};
        end
        if (pk > lvl && idx == pk - 1)
            return 24'h0F0F0F;
        return 24'h000000;
    endfunction

    task automatic chk_idle(input string tag);
        chk({tag, "_valid"}, 32'(o_valid), 0);
        chk({tag, "_busy"},  32'(o_busy),  0);
        chk({tag, "_data"},  32'(o_data),  0);
        chk({tag, "_idx"},   32'(o_idx),   0);
        chk({tag, "_last"},  32'(o_last),  0);
    endtask

    task automatic run_frame(input int level, input int ready_pct,
                             input int stall_at, input bit noise,
                             input int exp_cycles);
        int          lvl;
        int          n;
        int          cyc;
        int          stall;
        bit          rdy;
        logic [23:0] exp_q[$];
        lvl = (level > N) ? N : level;
`ifdef VU_PEAK_HOLD_EN
        if (lvl >= m_pk) begin
            m_pk   = lvl;
            m_hold = 8;
        end else if (m_hold > 0) begin
            m_hold--;
        end else if (m_pk > 0) begin
            m_pk--;
        end
`endif
        exp_q = {};
        for (int i = 0; i < N; i++)
            exp_q.push_back(ref_pixel(i, lvl, m_pk));
        @(negedge i_clk);
        i_start = 1'b1;
        i_level = IW'(level);
        i_ready = 1'b0;
        @(negedge i_clk);
        i_start = 1'b0;
        i_level = IW'($urandom);
        chk("first_busy", 32'(o_busy), 1);
        n     = 0;
        cyc   = 0;
        stall = 0;
        while (n < N && cyc < N * 40 + 20) begin
            chk("valid", 32'(o_valid), 1);
            chk("data",  32'(o_data),  32'(exp_q[n]));
            chk("idx",   32'(o_idx),   n);
            chk("last",  32'(o_last),  (n == N - 1) ? 1 : 0);
            rdy = ($urandom_range(0, 99) < ready_pct);
            if (n == stall_at && stall < 3) begin
                rdy = 1'b0;
                stall++;
            end
            i_ready = rdy;
            i_start = noise ? 1'($urandom_range(0, 1)) : 1'b0;
            i_level = IW'($urandom);
            if (rdy)
                n++;
            @(negedge i_clk);
            cyc++;
        end
        i_start = 1'b0;
        i_ready = 1'($urandom_range(0, 1));
        if (n < N)
            chk("timeout_words", n, N);
        if (exp_cycles >= 0)
            chk("frame_cycles", cyc, exp_cycles);
        chk_idle("end");
    endtask

    initial begin
        i_rst   = 1'b1;
        i_start = 1'b0;
        i_level = '0;
        i_ready = 1'b0;
        repeat (2) @(negedge i_clk);
        chk_idle("reset");
        i_rst = 1'b0;
        @(negedge i_clk);
        chk_idle("post_reset");

        // level 10, full speed: 20 words in 20 cycles
        run_frame(10, 100, -1, 1'b0, N);
        // level 31 clamps to 20
        run_frame(31, 100, -1, 1'b0, N);
        // backpressure at idx 5 for 3 cycles
        run_frame(7, 100, 5, 1'b0, N + 3);
        // level 0 with start pulses during the frame
        run_frame(0, 100, -1, 1'b1, N);

        // reset mid-frame aborts at once
        @(negedge i_clk);
        i_start = 1'b1;
        i_level = IW'(12);
        @(negedge i_clk);
        i_start = 1'b0;
        i_ready = 1'b1;
        repeat (4) @(negedge i_clk);
        #2 i_rst = 1'b1;
        #1;
        chk("rst_async_valid", 32'(o_valid), 0);
        chk("rst_async_busy",  32'(o_busy),  0);
        chk("rst_async_data",  32'(o_data),  0);
        m_pk   = 0;
        m_hold = 0;
        @(negedge i_clk);
        i_rst   = 1'b0;
        i_ready = 1'b0;
        run_frame(15, 100, -1, 1'b0, N);

        // randomized levels, ready patterns and spurious starts
        for (int f = 0; f < 8; f++)
            run_frame(int'($urandom_range(0, 31)),
                      int'($urandom_range(30, 100)),
                      int'($urandom_range(0, 25)) - 5, 1'b1, -1);

`ifdef VU_PEAK_HOLD_EN
        run_frame(18, 100, -1, 1'b0, N);
        for (int f = 0; f < 12; f++)
            run_frame(9, 100, -1, 1'b0, N);
`endif

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
